// File: rtl/cc_pkg.sv
// Shared types and constants for the cache-controller line-fill deserializer.
package cc_pkg;

   localparam int DATA_W   = 64;
   localparam int BEATS    = 8;
   localparam int OFFSET_W = 6;
   localparam int LINE_W   = DATA_W * BEATS;
   localparam int IDX_W    = $clog2(BEATS);
   localparam int BYTE_SH  = $clog2(DATA_W / 8);
   localparam logic [IDX_W-1:0] LAST_CNT = IDX_W'(BEATS - 1);

   typedef enum logic [1:0] {
      IDLE,
      COLLECT,
      PUSH
   } state_t;

   typedef struct packed {
      logic [OFFSET_W-1:0] offset;
      logic [LINE_W-1:0]   line;
   } fill_entry_t;

endpackage

// File: rtl/cc_deser_line_buf.sv
// Line assembly buffer: BEATS words of DATA_W bits, single indexed write port,
// whole line visible on a flat read port.
module cc_deser_line_buf #(
   parameter int DATA_W = 64,
   parameter int BEATS  = 8,
   parameter int IDX_W  = $clog2(BEATS)
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      wr_en,
   input  logic [IDX_W-1:0]          wr_idx,
   input  logic [DATA_W-1:0]         wr_data,
   output logic [DATA_W*BEATS-1:0]   line
);

   logic [DATA_W-1:0] words [BEATS];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < BEATS; k++) begin
            words[k] <= '0;
         end
      end else if (wr_en) begin
         words[wr_idx] <= wr_data;
      end
   end

   for (genvar g = 0; g < BEATS; g++) begin : g_flat
      assign line[g*DATA_W +: DATA_W] = words[g];
   end

endmodule

// File: rtl/cc_deserializer.sv
// Line-fill deserializer: rebuilds a critical-word-first wrapping burst into a natural-order
// line and pushes {byte offset, line} to the fill FIFO. Optional check: CC_DESER_PROTOCOL_CHECK_EN.
module cc_deserializer
   import cc_pkg::*;
(
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       off_valid_i,
   input  logic [IDX_W-1:0]           off_i,
   output logic                       off_ready_o,
   input  logic [DATA_W-1:0]          rdata_i,
   input  logic                       rvalid_i,
   input  logic                       rlast_i,
   output logic                       rready_o,
   input  logic                       fifo_full_i,
   output logic                       fifo_wren_o,
   output logic [OFFSET_W+LINE_W-1:0] fifo_wdata_o,
   output logic                       err_o
);

   state_t           state_q, state_d;
   logic [IDX_W-1:0] cnt_q;
   logic [IDX_W-1:0] off_q;
   logic [IDX_W-1:0] wr_idx;
   logic             beat_acc;
   logic [LINE_W-1:0] line;
   fill_entry_t      entry;

   assign beat_acc = rvalid_i & rready_o;
   // Wrapping placement: beat n of the burst lands in word (critical + n) mod BEATS.
   assign wr_idx   = off_q + cnt_q;

   always_comb begin
      state_d     = state_q;
      off_ready_o = 1'b0;
      rready_o    = 1'b0;
      fifo_wren_o = 1'b0;
      case (state_q)
         IDLE: begin
            off_ready_o = 1'b1;
            if (off_valid_i) state_d = COLLECT;
         end
         COLLECT: begin
            rready_o = 1'b1;
            if (rvalid_i && cnt_q == LAST_CNT) state_d = PUSH;
         end
         PUSH: begin
            fifo_wren_o = !fifo_full_i;
            if (!fifo_full_i) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         off_q   <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == IDLE && off_valid_i) begin
            off_q <= off_i;
            cnt_q <= '0;
         end else if (beat_acc) begin
            cnt_q <= cnt_q + IDX_W'(1);
         end
      end
   end

   cc_deser_line_buf #(
      .DATA_W (DATA_W),
      .BEATS  (BEATS),
      .IDX_W  (IDX_W)
   ) u_line_buf (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (beat_acc),
      .wr_idx  (wr_idx),
      .wr_data (rdata_i),
      .line    (line)
   );

   // Byte offset of the critical word within the line.
   assign entry.offset = OFFSET_W'(off_q) << BYTE_SH;
   assign entry.line   = line;
   assign fifo_wdata_o = entry;

`ifdef CC_DESER_PROTOCOL_CHECK_EN
   logic err_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_q <= 1'b0;
      end else if (beat_acc && (rlast_i != (cnt_q == LAST_CNT))) begin
         err_q <= 1'b1;
      end
   end

   assign err_o = err_q;
`else
   logic unused_rlast;
   assign unused_rlast = rlast_i;
   assign err_o        = 1'b0;
`endif

endmodule

// File: tb/tb_cc_deserializer.sv
// Randomized scoreboard bench for cc_deserializer: driver queues expected fill entries,
// a negedge monitor pops and compares on every FIFO write.
module tb_cc_deserializer;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         off_valid = 1'b0;
   logic [2:0]   off = '0;
   logic         off_ready;
   logic [63:0]  rdata = '0;
   logic         rvalid = 1'b0;
   logic         rlast = 1'b0;
   logic         rready;
   logic         fifo_full = 1'b0;
   logic         fifo_wren;
   logic [517:0] fifo_wdata;
   logic         err;

   int n_cmp  = 0;
   int n_fail = 0;
   logic [517:0] exp_q [$];

   cc_deserializer dut (
      .clk          (clk),
      .rst          (rst),
      .off_valid_i  (off_valid),
      .off_i        (off),
      .off_ready_o  (off_ready),
      .rdata_i      (rdata),
      .rvalid_i     (rvalid),
      .rlast_i      (rlast),
      .rready_o     (rready),
      .fifo_full_i  (fifo_full),
      .fifo_wren_o  (fifo_wren),
      .fifo_wdata_o (fifo_wdata),
      .err_o        (err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [517:0] act, input logic [517:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: every FIFO write must match the oldest outstanding expected line.
   always @(negedge clk) begin
      if (!rst && fifo_wren) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_write", 518'(fifo_wren), 518'(0));
         end else begin
            chk("fifo_entry", fifo_wdata, exp_q.pop_front());
         end
      end
   end

   // mode: 0 = no stalls, 1 = rvalid every other cycle, 2 = random rvalid.
   // abort_at > 0: pulse reset after that many accepted beats. bad_last: beat index carrying a wrong rlast.
   task automatic burst(input logic [2:0] o, input int mode, input int full_cyc,
                        input bit hold, input int abort_at, input int bad_last);
      logic [63:0]  d [8];
      logic [517:0] exp_e;
      int i, guard;
      bit v, acc, phase;
      exp_e = '0;
      for (int k = 0; k < 8; k++) begin
         d[k] = {$urandom, $urandom};
         exp_e[((int'(o) + k) % 8) * 64 +: 64] = d[k];
      end
      exp_e[517:512] = 6'(int'(o) * 8);

      off_valid = 1'b1;
      off = o;
      guard = 0;
      @(negedge clk);
      while (!off_ready && guard < 20) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 20) chk("off_ready_timeout", 518'(off_ready), 518'(1));
      @(posedge clk); #1;
      off_valid = 1'b0;
      off = 3'($urandom);
      fifo_full = (full_cyc > 0);

      i = 0; guard = 0; phase = 1'b1;
      while (i < 8 && guard < 200) begin
         case (mode)
            0: v = 1'b1;
            1: begin v = phase; phase = ~phase; end
            default: v = 1'($urandom % 2);
         endcase
         rvalid = v;
         rdata  = v ? d[i] : {$urandom, $urandom};
         rlast  = v && ((i == 7) != (i == bad_last));
         @(negedge clk);
         chk("rready_collect", 518'(rready), 518'(1));
         acc = v && rready;
         @(posedge clk); #1;
         if (acc) i++;
         guard++;
         if (abort_at > 0 && i == abort_at) begin
            rvalid = 1'b0;
            rlast  = 1'b0;
            rst    = 1'b1;
            #1;
            chk("abort_off_ready", 518'(off_ready), 518'(1));
            chk("abort_rready", 518'(rready), 518'(0));
            chk("abort_wren", 518'(fifo_wren), 518'(0));
            chk("abort_wdata", fifo_wdata, 518'(0));
            @(posedge clk); #1;
            rst = 1'b0;
            fifo_full = 1'b0;
            return;
         end
      end
      if (guard >= 200) chk("beat_timeout", 518'(i), 518'(8));

      rvalid = hold;
      rdata  = {$urandom, $urandom};
      rlast  = 1'b0;
      exp_q.push_back(exp_e);
      for (int c = 0; c < full_cyc; c++) begin
         @(negedge clk);
         chk("wren_while_full", 518'(fifo_wren), 518'(0));
         chk("rready_push", 518'(rready), 518'(0));
         chk("data_hold_full", fifo_wdata, exp_e);
         @(posedge clk); #1;
      end
      fifo_full = 1'b0;
      @(negedge clk);
      chk("write_latency", 518'(fifo_wren), 518'(1));
      chk("rready_push", 518'(rready), 518'(0));
      @(posedge clk); #1;
      @(negedge clk);
      chk("idle_off_ready", 518'(off_ready), 518'(1));
      chk("idle_rready", 518'(rready), 518'(0));
      chk("idle_wren", 518'(fifo_wren), 518'(0));
      @(posedge clk); #1;
      rvalid = 1'b0;
   endtask

   initial begin
      #2000000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

   initial begin
      rst = 1'b1;
      repeat (2) @(negedge clk);
      chk("rst_off_ready", 518'(off_ready), 518'(1));
      chk("rst_rready", 518'(rready), 518'(0));
      chk("rst_wren", 518'(fifo_wren), 518'(0));
      chk("rst_err", 518'(err), 518'(0));
      chk("rst_wdata", fifo_wdata, 518'(0));
      @(posedge clk); #1;
      rst = 1'b0;

      burst(3'd0, 0, 0, 1'b0, 0, -1);
      burst(3'd2, 0, 0, 1'b0, 0, -1);
      burst(3'd5, 1, 0, 1'b0, 0, -1);
      burst(3'd6, 0, 4, 1'b1, 0, -1);
      burst(3'd3, 0, 0, 1'b0, 4, -1);
      chk("abort_no_write", 518'(exp_q.size()), 518'(0));
      burst(3'd1, 2, 0, 1'b0, 0, -1);
      chk("err_clean", 518'(err), 518'(0));
`ifdef CC_DESER_PROTOCOL_CHECK_EN
      burst(3'd4, 0, 0, 1'b0, 0, 2);
      chk("err_set", 518'(err), 518'(1));
`endif
      for (int b = 0; b < 8; b++) begin
         burst(3'($urandom), int'($urandom % 3), int'($urandom % 3), 1'($urandom % 2), 0, -1);
      end
      repeat (3) @(negedge clk);
      chk("queue_drained", 518'(exp_q.size()), 518'(0));
`ifdef CC_DESER_PROTOCOL_CHECK_EN
      chk("err_sticky", 518'(err), 518'(1));
`else
      chk("err_tied_low", 518'(err), 518'(0));
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
